// File: rtl/handshake_mem_copier_if.sv
// handshake_mem_copier_if: Avalon-MM master/slave bundle used by the copier
interface handshake_mem_copier_if #(parameter int ADDR_W = 15);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;
  modport master(output address, read, write, writedata, byteenable,
                 input waitrequest, readdata, readdatavalid);
  modport slave(input address, read, write, writedata, byteenable,
                output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/handshake_mem_copier.sv
// handshake_mem_copier: word-by-word Avalon-MM block copy with running checksum
module handshake_mem_copier #(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [LEN_W-1:0]      num_words,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum,
  handshake_mem_copier_if.master avm
);
  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, src_n, dst_n;
  logic [LEN_W-1:0] cnt;
  logic go, wr_acc, rd_cap;
  assign avm.byteenable = 4'hF;
  // next-state and next-pointer decode; pointers step only when a write is accepted
  always_comb begin
    go     = (state == IDLE) && start;
    wr_acc = (state == WR) && !avm.waitrequest;
    rd_cap = (state == RDWAIT) && avm.readdatavalid;
    src_n  = go ? {src_addr[ADDR_W-1:2], 2'b00} : wr_acc ? src_ptr + ADDR_W'(4) : src_ptr;
    dst_n  = go ? {dst_addr[ADDR_W-1:2], 2'b00} : wr_acc ? dst_ptr + ADDR_W'(4) : dst_ptr;
    state_n = state;
    case (state)
      IDLE:    state_n = go ? ((num_words == '0) ? DONE : RD) : IDLE;
      RD:      state_n = avm.waitrequest ? RD : RDWAIT;
      RDWAIT:  state_n = avm.readdatavalid ? WR : RDWAIT;
      WR:      state_n = avm.waitrequest ? WR : ((cnt == LEN_W'(1)) ? DONE : RD);
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end
  // datapath and registered outputs, all derived from the upcoming state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_ptr       <= '0;
      dst_ptr       <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      checksum      <= '0;
      avm.read      <= 1'b0;
      avm.write     <= 1'b0;
      avm.address   <= '0;
      avm.writedata <= '0;
    end else begin
      src_ptr       <= src_n;
      dst_ptr       <= dst_n;
      cnt           <= go ? num_words : wr_acc ? cnt - LEN_W'(1) : cnt;
      checksum      <= go ? '0 : rd_cap ? checksum + avm.readdata : checksum;
      avm.writedata <= rd_cap ? avm.readdata : avm.writedata;
      avm.read      <= state_n == RD;
      avm.write     <= state_n == WR;
      busy          <= state_n inside {RD, RDWAIT, WR};
      done          <= state_n == DONE;
      avm.address   <= (state_n == WR) ? dst_n : (state_n == RD) ? src_n : avm.address;
    end
  end
endmodule

// File: tb/tb_handshake_mem_copier.sv
// tb_handshake_mem_copier: randomized Avalon slave plus copy-list scoreboard
module tb_handshake_mem_copier;
  localparam int ADDR_W = 15;
  localparam int LEN_W  = 13;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0, dst_addr = '0;
  logic [LEN_W-1:0]  num_words = '0;
  logic busy, done;
  logic [31:0] checksum;
  handshake_mem_copier_if #(.ADDR_W(ADDR_W)) avm();
  handshake_mem_copier #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_words(num_words), .busy(busy), .done(done), .checksum(checksum), .avm(avm.master));
  always #5 clk = ~clk;

  logic [31:0] mem [0:8191];
  int n_chk = 0, n_err = 0;
  bit stall = 0, spur = 0, hold = 0, mon_en = 0;
  int lat_max = 1, n_rd = 0, n_wr = 0, hold_rd = 0, hold_wr = 0;
  logic [ADDR_W-1:0] exp_rd[$], exp_wa[$], rd_log[$], wr_log[$];
  logic [31:0] exp_wd[$], exp_cp[$];
  logic [31:0] exp_sum, exp_part;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory slave: random stall, variable read latency, optional stray readdatavalid
  initial begin
    logic ra, wa;
    logic [ADDR_W-1:0] a, rd_a;
    logic [31:0] wd;
    bit pend;
    int cd;
    pend = 0; cd = 0; rd_a = '0;
    avm.waitrequest = 1'b0; avm.readdatavalid = 1'b0; avm.readdata = '0;
    forever begin
      @(negedge clk);
      ra = reset_n && avm.read && !avm.waitrequest;
      wa = reset_n && avm.write && !avm.waitrequest;
      a = avm.address; wd = avm.writedata;
      @(posedge clk); #1;
      if (wa === 1'b1) begin mem[a / 4] = wd; n_wr++; end
      if (ra === 1'b1) begin pend = 1; cd = $urandom_range(1, lat_max); rd_a = a; n_rd++; end
      avm.readdatavalid = 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin avm.readdatavalid = 1'b1; avm.readdata = mem[rd_a / 4]; pend = 0; end
      end else if (spur && $urandom_range(0, 3) == 0) begin
        avm.readdatavalid = 1'b1; avm.readdata = $urandom;
      end
      avm.waitrequest = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      if (hold && n_wr == hold_wr && n_rd == hold_rd) avm.waitrequest = 1'b1;
    end
  end

  // per-cycle compare against the expected copy list
  initial begin
    logic p_rs, p_ws;
    logic [ADDR_W-1:0] p_a;
    logic [31:0] p_d;
    p_rs = 0; p_ws = 0; p_a = '0; p_d = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("byteenable", 32'(avm.byteenable), 32'hF);
        check("rd_wr_excl", 32'(avm.read & avm.write), 32'd0);
        if (p_rs) begin check("rd_hold", 32'(avm.read), 32'd1); check("rd_hold_addr", 32'(avm.address), 32'(p_a)); end
        if (p_ws) begin
          check("wr_hold", 32'(avm.write), 32'd1);
          check("wr_hold_addr", 32'(avm.address), 32'(p_a));
          check("wr_hold_data", avm.writedata, p_d);
        end
        p_rs = reset_n && avm.read && avm.waitrequest;
        p_ws = reset_n && avm.write && avm.waitrequest;
        p_a = avm.address; p_d = avm.writedata;
        if (reset_n && avm.read && !avm.waitrequest) begin
          rd_log.push_back(avm.address);
          if (exp_rd.size() == 0) begin n_chk++; n_err++; $display("FAIL rd_unexpected: got read at %h expected none", avm.address); end
          else check("rd_addr", 32'(avm.address), 32'(exp_rd.pop_front()));
        end
        if (reset_n && avm.write && !avm.waitrequest) begin
          wr_log.push_back(avm.address);
          if (exp_wa.size() == 0) begin n_chk++; n_err++; $display("FAIL wr_unexpected: got write at %h expected none", avm.address); end
          else begin
            exp_part = exp_part + exp_wd[0];
            check("wr_addr", 32'(avm.address), 32'(exp_wa.pop_front()));
            check("wr_data", avm.writedata, exp_wd.pop_front());
            check("run_sum", checksum, exp_part);
          end
        end
      end
    end
  end

  task automatic issue(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input int n);
    int sb, db, ra, wa;
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; num_words = LEN_W'(n);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_cp.delete();
    exp_sum = '0; exp_part = '0;
    sb = int'(s) - int'(s) % 4; db = int'(d) - int'(d) % 4;
    for (int i = 0; i < n; i++) begin
      ra = (sb + 4 * i) % 32768; wa = (db + 4 * i) % 32768;
      exp_rd.push_back(ADDR_W'(ra)); exp_wa.push_back(ADDR_W'(wa));
      exp_wd.push_back(mem[ra / 4]); exp_cp.push_back(mem[ra / 4]);
      exp_sum = exp_sum + mem[ra / 4];
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input int n,
                         input bit poke, output int dc);
    int db;
    issue(s, d, n);
    dc = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (poke && i == 5) begin start = 1'b1; src_addr = 15'h0044; num_words = 7; end
      if (poke && i == 6) start = 1'b0;
      if (done) begin dc = i; break; end
      check("busy_during", 32'(busy), 32'(n > 0));
    end
    if (dc < 0) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end else begin
      check("done_busy", 32'(busy), 32'd0);
      check("done_rd", 32'(avm.read), 32'd0);
      check("done_wr", 32'(avm.write), 32'd0);
      check("checksum", checksum, exp_sum);
      check("rd_left", 32'(exp_rd.size()), 32'd0);
      check("wr_left", 32'(exp_wa.size()), 32'd0);
      if (!stall && lat_max == 1) check("done_cycle", 32'(dc), 32'(1 + 3 * n));
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("ck_hold", checksum, exp_sum);
      db = int'(d) - int'(d) % 4;
      for (int i = 0; i < n; i++) check("dst_mem", mem[((db + 4 * i) % 32768) / 4], exp_cp[i]);
    end
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ck", checksum, 32'd0);
    check("rst_rd", 32'(avm.read), 32'd0);
    check("rst_wr", 32'(avm.write), 32'd0);
    check("rst_addr", 32'(avm.address), 32'd0);
    check("rst_wd", avm.writedata, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1; mon_en = 1;
    // basic copy
    for (int i = 0; i < 4; i++) begin mem[i] = 32'(i + 1); mem[1024 + i] = '0; end
    rd_log.delete(); wr_log.delete();
    do_copy(15'h0000, 15'h1000, 4, 0, dc);
    check("basic_ck", checksum, 32'd10);
    check("basic_cycle", 32'(dc), 32'd13);
    check("basic_nrd", 32'(rd_log.size()), 32'd4);
    check("basic_nwr", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("basic_dst", mem[1024 + i], 32'(i + 1));
    // zero length
    rd_log.delete(); wr_log.delete();
    do_copy(15'h0040, 15'h0080, 0, 0, dc);
    check("zero_ck", checksum, 32'd0);
    check("zero_cycle", 32'(dc), 32'd1);
    check("zero_nrd", 32'(rd_log.size() + wr_log.size()), 32'd0);
    // backpressure, variable latency, stray valids, start while busy, sum wrap
    stall = 1; lat_max = 4; spur = 1;
    for (int i = 0; i < 16; i++) mem[2048 + i] = $urandom;
    mem[2048] = 32'hFFFF_FFFF; mem[2049] = 32'h1;
    do_copy(15'h2000, 15'h3000, 16, 1, dc);
    check("bp_dst0", mem[3072], 32'hFFFF_FFFF);
    check("bp_dst1", mem[3073], 32'h1);
    // address wrap
    rd_log.delete();
    do_copy(15'h7FF8, 15'h0100, 3, 0, dc);
    check("wrap_n", 32'(rd_log.size()), 32'd3);
    check("wrap_a0", 32'(rd_log[0]), 32'h7FF8);
    check("wrap_a1", 32'(rd_log[1]), 32'h7FFC);
    check("wrap_a2", 32'(rd_log[2]), 32'h0000);
    // unaligned addresses
    stall = 0; lat_max = 1;
    rd_log.delete(); wr_log.delete();
    do_copy(15'h0003, 15'h0203, 2, 0, dc);
    check("unal_rd", 32'(rd_log[0]), 32'h0000);
    check("unal_wr", 32'(wr_log[0]), 32'h0200);
    // reset during the second word's stalled write
    hold_rd = n_rd + 2; hold_wr = n_wr + 1; hold = 1;
    issue(15'h0800, 15'h0A00, 4);
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (avm.write && n_rd == hold_rd) begin dc = i; break; end
    end
    check("mid_wr2_seen", 32'(dc >= 0), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_ck", checksum, 32'd0);
    check("mid_rd", 32'(avm.read), 32'd0);
    check("mid_wr", 32'(avm.write), 32'd0);
    check("mid_addr", 32'(avm.address), 32'd0);
    check("mid_wd", avm.writedata, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1; hold = 0;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    do_copy(15'h0C00, 15'h0E00, 5, 0, dc);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
